bus_arbiter_rr: RTL and testbench

- Round-robin arbiter and mux for the shared system bus.
- Accepts up to NUM_DEVICES master requests and grants exactly one master at a time.
- Muxes the granted master's data and control words onto the bus.
- Decodes the target field of the control word into a one-hot slave enable.
- Sits at system top between all bus devices (CPU, VGA, UART, SRAM controller, PS2, audio) and the shared bus_data/bus_ctrl nets.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 34 +++
 rtl/bus_arbiter_rr.sv | 141 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus: control-word field positions,
// fixed device IDs and the arbiter state encoding.
package bus_pkg;

  // Field positions are counted downward from the control-word MSB so the
  // same constants hold for any control width.
  localparam int CTRL_VALID_BIT = 0;
  localparam int CTRL_TGT_MSB   = 1;
  localparam int CTRL_TGT_LSB   = 3;

  localparam logic [2:0] DEV_RAM  = 3'd0;
  localparam logic [2:0] DEV_ROM  = 3'd1;
  localparam logic [2:0] DEV_VGA  = 3'd2;
  localparam logic [2:0] DEV_PS2  = 3'd3;
  localparam logic [2:0] DEV_ACP  = 3'd4;
  localparam logic [2:0] DEV_UART = 3'd6;
  localparam logic [2:0] DEV_CPU  = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request after i_rr_ptr, wrapping.
// Shared by the bus arbiter and any later DMA arbiter.
module rr_priority_pick #(
  parameter  int N  = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_rr_ptr,
  output logic [N-1:0]  o_win,
  output logic [PW-1:0] o_win_idx,
  output logic          o_valid
);

  logic [PW-1:0] w_idx;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    o_valid   = 1'b0;
    w_idx     = '0;
    // N is a power of two, so PW-bit addition wraps modulo N by itself.
    for (int k = 1; k <= N; k++) begin
      w_idx = i_rr_ptr + PW'(k);
      if (!o_valid && i_req[w_idx]) begin
        o_valid   = 1'b1;
        o_win_idx = w_idx;
      end
    end
    o_win[o_win_idx] = o_valid;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter and data/control mux with target decode.
// Optional watchdog release is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_DEVICES    = 8,
  parameter int D_WIDTH        = 32,
  parameter int C_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_DEVICES-1:0]         req,
  input  logic [NUM_DEVICES*D_WIDTH-1:0] bus_in,
  input  logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in,
  output logic [NUM_DEVICES-1:0]         master_ack,
  output logic [NUM_DEVICES-1:0]         slave_en,
  output logic [D_WIDTH-1:0]             bus_out,
  output logic [C_WIDTH-1:0]             ctrl_out,
  output logic [2:0]                     grant_id,
  output logic                           bus_busy,
  output logic                           timeout_err
);

  localparam int PW        = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int VALID_POS = C_WIDTH - 1 - CTRL_VALID_BIT;
  localparam int TGT_HI    = C_WIDTH - 1 - CTRL_TGT_MSB;
  localparam int TGT_LO    = C_WIDTH - 1 - CTRL_TGT_LSB;

  arb_state_t             r_state;
  logic [NUM_DEVICES-1:0] r_ack;
  logic [PW-1:0]          r_gid;
  logic [PW-1:0]          r_rr_ptr;

  logic                   w_busy;
  logic                   w_expire;
  logic [NUM_DEVICES-1:0] w_elig;
  logic [NUM_DEVICES-1:0] w_pick_oh;
  logic [PW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic [2:0]             w_tgt;

  assign w_busy = (r_state == BUSY);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]       r_to_cnt;
  logic [NUM_DEVICES-1:0] r_mask;
  logic                   r_to_err;

  assign w_expire    = w_busy && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_elig      = req & ~r_mask;
  assign timeout_err = r_to_err;

  // A timed-out master stays masked until it lets go of req for a cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_to_cnt <= '0;
      r_mask   <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= w_busy ? r_to_cnt + 1'b1 : '0;
      r_mask   <= (r_mask | (w_expire ? r_ack : '0)) & req;
      r_to_err <= w_expire;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expire         = 1'b0;
  assign w_elig           = req;
  assign timeout_err      = 1'b0;
`endif

  rr_priority_pick #(.N(NUM_DEVICES)) u_pick (
    .i_req     (w_elig),
    .i_rr_ptr  (r_rr_ptr),
    .o_win     (w_pick_oh),
    .o_win_idx (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= IDLE;
      r_ack    <= '0;
      r_gid    <= '0;
      r_rr_ptr <= PW'(NUM_DEVICES - 1);
    end else begin
      case (r_state)
        // RELEASE is the dead turnaround cycle; it arbitrates for the next edge.
        IDLE, RELEASE: begin
          if (w_pick_valid) begin
            r_state <= BUSY;
            r_ack   <= w_pick_oh;
            r_gid   <= w_pick_idx;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (!req[r_gid] || w_expire) begin
            r_state  <= RELEASE;
            r_ack    <= '0;
            r_rr_ptr <= r_gid;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign master_ack = r_ack;
  assign bus_busy   = w_busy;
  assign grant_id   = w_busy ? 3'(r_gid) : 3'd0;

  always_comb begin
    bus_out  = '0;
    ctrl_out = '0;
    if (w_busy) begin
      bus_out  = bus_in[int'(r_gid)*D_WIDTH +: D_WIDTH];
      ctrl_out = ctrl_in[int'(r_gid)*C_WIDTH +: C_WIDTH];
    end
  end

  assign w_tgt = ctrl_out[TGT_HI:TGT_LO];

  // Targets outside the port range or equal to the owner decode to nothing.
  always_comb begin
    slave_en = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      slave_en[i] = w_busy && ctrl_out[VALID_POS] &&
                    (w_tgt == 3'(i)) && (w_tgt != 3'(r_gid));
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scoreboard bench for bus_arbiter_rr: latency, turnaround,
// round-robin order, slave decode, async reset and optional timeout.
module tb_bus_arbiter_rr;
  import bus_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_L;
  logic [N-1:0]    req;
  logic [N*DW-1:0] bus_in;
  logic [N*CW-1:0] ctrl_in;
  logic [N-1:0]    master_ack;
  logic [N-1:0]    slave_en;
  logic [DW-1:0]   bus_out;
  logic [CW-1:0]   ctrl_out;
  logic [2:0]      grant_id;
  logic            bus_busy;
  logic            timeout_err;

  logic [DW-1:0] dev_data [N];
  logic [CW-1:0] dev_ctrl [N];

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [N-1:0]  sen;
    logic [DW-1:0] dout;
    logic [CW-1:0] cout;
    logic [2:0]    gid;
    logic          busy;
    logic          to_err;
  } snap_t;

  snap_t exp_q [$];
  string tag_q [$];
  int    total = 0;
  int    bad   = 0;

  bus_arbiter_rr #(
    .NUM_DEVICES    (N),
    .D_WIDTH        (DW),
    .C_WIDTH        (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .req         (req),
    .bus_in      (bus_in),
    .ctrl_in     (ctrl_in),
    .master_ack  (master_ack),
    .slave_en    (slave_en),
    .bus_out     (bus_out),
    .ctrl_out    (ctrl_out),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus_in[i*DW +: DW]  = dev_data[i];
      ctrl_in[i*CW +: CW] = dev_ctrl[i];
    end
  end

  function automatic snap_t idle_snap(logic to_err);
    snap_t s;
    s        = '0;
    s.to_err = to_err;
    return s;
  endfunction

  // Expected bus view while device g owns the bus.
  function automatic snap_t own_snap(int g);
    snap_t      s;
    logic [2:0] tgt;
    s      = '0;
    s.ack  = N'(1) << g;
    s.busy = 1'b1;
    s.gid  = 3'(g);
    s.dout = dev_data[g];
    s.cout = dev_ctrl[g];
    tgt    = s.cout[6:4];
    if (s.cout[7] && (tgt != 3'(g)))
      s.sen = N'(1) << tgt;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.ack    = master_ack;
    s.sen    = slave_en;
    s.dout   = bus_out;
    s.cout   = ctrl_out;
    s.gid    = grant_id;
    s.busy   = bus_busy;
    s.to_err = timeout_err;
    return s;
  endfunction

  task automatic push(input string t, input snap_t s);
    exp_q.push_back(s);
    tag_q.push_back(t);
  endtask

  task automatic check();
    snap_t e;
    snap_t o;
    string t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h required=expectation", observe());
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observe();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", t, o, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    req     = '0;
    #1;
    push("reset_state", idle_snap(1'b0));
    check();
    step();
    step();
    reset_L = 1'b1;
  endtask

  initial begin
    int cur;
    int order [5];
    order = '{6, 7, 2, 6, 7};
    for (int i = 0; i < N; i++) begin
      dev_data[i] = 32'hA000_0000 + i * 32'h0101_0101;
      dev_ctrl[i] = {1'b1, 3'(i + 1), 4'(i)};
    end
    reset_L = 1'b0;
    req     = '0;

    // Grant latency, slave decode and turnaround on the CPU port.
    do_reset();
    dev_ctrl[DEV_CPU] = 8'b1000_0000;
    req = 8'h80;
    #1;
    push("pre_grant", idle_snap(1'b0));
    check();
    step();
    push("cpu_grant", own_snap(7));
    check();
    dev_ctrl[DEV_CPU] = 8'b1111_0000;
    #1;
    push("sen_self", own_snap(7));
    check();
    dev_ctrl[DEV_CPU] = 8'b0011_0000;
    #1;
    push("sen_invalid", own_snap(7));
    check();
    dev_ctrl[DEV_CPU] = 8'b1010_0101;
    #1;
    push("sen_vga", own_snap(7));
    check();
    req = 8'h00;
    step();
    push("drop_ack", idle_snap(1'b0));
    check();
    step();
    push("turnaround", idle_snap(1'b0));
    check();

    // All ports requesting from reset: service 0,1,2,... in order.
    do_reset();
    req = 8'hFF;
    step();
    push("all_first", own_snap(0));
    check();
    for (int g = 0; g < N - 1; g++) begin
      step();
      push("all_hold", own_snap(g));
      check();
      req[g] = 1'b0;
      step();
      push("all_release", idle_snap(1'b0));
      check();
      req[g] = 1'b1;
      step();
      push("all_next", own_snap(g + 1));
      check();
    end

    // Fairness among devices 2, 6, 7 re-requesting after each release.
    do_reset();
    req = 8'hC4;
    step();
    push("rr_first", own_snap(2));
    check();
    cur = 2;
    for (int k = 0; k < 5; k++) begin
      repeat (2) begin
        step();
        push("rr_hold", own_snap(cur));
        check();
      end
      req[cur] = 1'b0;
      step();
      push("rr_release", idle_snap(1'b0));
      check();
      req[cur] = 1'b1;
      step();
      push("rr_next", own_snap(order[k]));
      check();
      cur = order[k];
    end

    // Asynchronous reset in the middle of a UART transaction.
    do_reset();
    dev_ctrl[DEV_UART] = 8'h90;
    req = 8'h40;
    step();
    push("uart_grant", own_snap(6));
    check();
    reset_L = 1'b0;
    #1;
    push("mid_reset", idle_snap(1'b0));
    check();
    req = 8'h41;
    #2;
    reset_L = 1'b1;
    step();
    push("post_reset_dev0", own_snap(0));
    check();

`ifdef BUS_ARB_TIMEOUT_EN
    // VGA never lets go: forced release after 16 BUSY cycles, then masked.
    do_reset();
    req = 8'h84;
    step();
    push("to_grant", own_snap(2));
    check();
    for (int c = 2; c <= TO; c++) begin
      step();
      push("to_hold", own_snap(2));
      check();
    end
    step();
    push("to_fire", idle_snap(1'b1));
    check();
    step();
    push("to_cpu_next", own_snap(7));
    check();
    req = 8'h04;
    step();
    push("to_cpu_release", idle_snap(1'b0));
    check();
    step();
    push("to_vga_masked", idle_snap(1'b0));
    check();
    req = 8'h00;
    step();
    push("to_vga_low", idle_snap(1'b0));
    check();
    req = 8'h04;
    step();
    push("to_vga_regrant", own_snap(2));
    check();
`else
    // Without the watchdog a stuck owner simply keeps the bus.
    do_reset();
    req = 8'h04;
    step();
    push("hold_grant", own_snap(2));
    check();
    repeat (2 * TO) step();
    push("no_timeout", own_snap(2));
    check();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
